// File: rtl/dioptase_alu.sv
// dioptase_alu -- execute-stage integer ALU for the Dioptase pipeline.
// Produces a combinational 32-bit result for ALU, upper-immediate and
// memory-address opcodes, and keeps registered C/Z/S/O flags that the
// next instruction's branch-condition logic consumes.
// Optional feature macro: ALU_MUL_EN enables the 32x32 low-word multiply
// on alu_op 18. When the macro is undefined, alu_op 18 is reserved.
module dioptase_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  opcode,
   input  logic [4:0]  alu_op,
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   input  logic        bubble_in,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   // Instruction classes
   localparam logic [4:0] OPC_REG_ALU = 5'd0;
   localparam logic [4:0] OPC_IMM_ALU = 5'd1;
   localparam logic [4:0] OPC_UPPER   = 5'd2;
   localparam logic [4:0] OPC_MEM_LO  = 5'd3;
   localparam logic [4:0] OPC_MEM_HI  = 5'd11;

   // ALU operations
   localparam logic [4:0] OP_AND  = 5'd0;
   localparam logic [4:0] OP_NAND = 5'd1;
   localparam logic [4:0] OP_OR   = 5'd2;
   localparam logic [4:0] OP_NOR  = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_XNOR = 5'd5;
   localparam logic [4:0] OP_NOT  = 5'd6;
   localparam logic [4:0] OP_LSL  = 5'd7;
   localparam logic [4:0] OP_LSR  = 5'd8;
   localparam logic [4:0] OP_ASR  = 5'd9;
   localparam logic [4:0] OP_ROTL = 5'd10;
   localparam logic [4:0] OP_ROTR = 5'd11;
   localparam logic [4:0] OP_ADD  = 5'd14;
   localparam logic [4:0] OP_ADDC = 5'd15;
   localparam logic [4:0] OP_SUB  = 5'd16;
   localparam logic [4:0] OP_SUBB = 5'd17;
`ifdef ALU_MUL_EN
   localparam logic [4:0] OP_MUL  = 5'd18;
`endif

   // Flag bit positions inside the flag vector
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_S = 2;
   localparam int FLAG_O = 3;

   logic [3:0]  flags_q;
   logic [3:0]  flags_d;
   logic        flag_update;

   logic [31:0] addend_b;
   logic        add_cin;
   logic [32:0] add_sum;
   logic [31:0] mem_addr;

   logic [4:0]  sh_amt;
   logic [5:0]  sh_comp;
   logic [31:0] shl_res;
   logic [31:0] shr_res;
   logic [31:0] asr_res;
   logic [31:0] rotl_res;
   logic [31:0] rotr_res;

`ifdef ALU_MUL_EN
   logic [31:0] mul_res;
`endif

   logic [31:0] alu_res;
   logic        alu_c;
   logic        alu_o;

   // Shared adder: subtraction is lhs + ~rhs + cin, carry-in chained from C
   always_comb begin
      addend_b = rhs;
      add_cin  = 1'b0;
      case (alu_op)
         OP_ADDC: add_cin = flags_q[FLAG_C];
         OP_SUB: begin
            addend_b = ~rhs;
            add_cin  = 1'b1;
         end
         OP_SUBB: begin
            addend_b = ~rhs;
            add_cin  = flags_q[FLAG_C];
         end
         default: ;
      endcase
      add_sum = {1'b0, lhs} + {1'b0, addend_b} + {32'd0, add_cin};
   end

   // Memory opcodes use a separate plain adder so address generation never
   // depends on alu_op or on the registered carry.
   assign mem_addr = lhs + rhs;

   // Shifters and rotators; a zero rotate amount shifts the wrap term by 32,
   // which yields zero and leaves lhs unchanged.
   assign sh_amt   = rhs[4:0];
   assign sh_comp  = 6'd32 - {1'b0, sh_amt};
   assign shl_res  = lhs << sh_amt;
   assign shr_res  = lhs >> sh_amt;
   assign asr_res  = $signed(lhs) >>> sh_amt;
   assign rotl_res = (lhs << sh_amt) | (lhs >> sh_comp);
   assign rotr_res = (lhs >> sh_amt) | (lhs << sh_comp);

`ifdef ALU_MUL_EN
   assign mul_res  = lhs * rhs;
`endif

   // ALU operation select; C and O are only meaningful for the adder ops
   always_comb begin
      alu_res = 32'd0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      case (alu_op)
         OP_AND:  alu_res = lhs & rhs;
         OP_NAND: alu_res = ~(lhs & rhs);
         OP_OR:   alu_res = lhs | rhs;
         OP_NOR:  alu_res = ~(lhs | rhs);
         OP_XOR:  alu_res = lhs ^ rhs;
         OP_XNOR: alu_res = ~(lhs ^ rhs);
         OP_NOT:  alu_res = ~rhs;
         OP_LSL:  alu_res = shl_res;
         OP_LSR:  alu_res = shr_res;
         OP_ASR:  alu_res = asr_res;
         OP_ROTL: alu_res = rotl_res;
         OP_ROTR: alu_res = rotr_res;
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
            alu_res = add_sum[31:0];
            alu_c   = add_sum[32];
            // Signed overflow of the actual adder inputs; for subtraction the
            // inverted rhs makes this "operand signs differ, result != lhs".
            alu_o   = (lhs[31] == addend_b[31]) && (add_sum[31] != lhs[31]);
         end
`ifdef ALU_MUL_EN
         OP_MUL:  alu_res = mul_res;
`endif
         default: alu_res = 32'd0;
      endcase
   end

   // Result select by instruction class
   always_comb begin
      result = 32'd0;
      if (opcode == OPC_REG_ALU || opcode == OPC_IMM_ALU) begin
         result = alu_res;
      end else if (opcode == OPC_UPPER) begin
         result = rhs;
      end else if (opcode >= OPC_MEM_LO && opcode <= OPC_MEM_HI) begin
         result = mem_addr;
      end
   end

   // Next flag value, taken from the ALU result itself
   always_comb begin
      flags_d         = 4'b0000;
      flags_d[FLAG_C] = alu_c;
      flags_d[FLAG_Z] = (alu_res == 32'd0);
      flags_d[FLAG_S] = alu_res[31];
      flags_d[FLAG_O] = alu_o;
   end

   assign flag_update = !bubble_in &&
                        (opcode == OPC_REG_ALU || opcode == OPC_IMM_ALU);

   // Flag register: reset wins, otherwise only valid ALU instructions write
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else if (flag_update) begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: tb/tb_dioptase_alu.sv
// tb_dioptase_alu -- self-checking bench for dioptase_alu.
// Directed vectors plus randomized traffic against an arithmetic reference
// model. Define ALU_MUL_EN for both bench and design to cover the multiply.
`timescale 1ns/1ps
module tb_dioptase_alu;

   logic        clk;
   logic        rst;
   logic [4:0]  opcode;
   logic [4:0]  alu_op;
   logic [31:0] lhs;
   logic [31:0] rhs;
   logic        bubble_in;
   logic [31:0] result;
   logic [3:0]  flags;

   int errors;
   int checks;

   // Model copy of the architectural flags {O,S,Z,C}
   logic [3:0] m_flags;

   dioptase_alu dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .alu_op    (alu_op),
      .lhs       (lhs),
      .rhs       (rhs),
      .bubble_in (bubble_in),
      .result    (result),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: integer arithmetic on 64-bit values, bit-loop shifts.
   task automatic ref_model(input logic [4:0] opc, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic c_in, output logic [31:0] res,
                            output logic [3:0] nf);
      longint     wide;
      longint     sgn;
      logic       c;
      logic       o;
      logic [31:0] r;
      int         sh;
      c  = 1'b0;
      o  = 1'b0;
      r  = 32'd0;
      sh = int'(b[4:0]);
      case (op)
         5'd0:  r = a & b;
         5'd1:  r = ~(a & b);
         5'd2:  r = a | b;
         5'd3:  r = ~(a | b);
         5'd4:  r = a ^ b;
         5'd5:  r = ~(a ^ b);
         5'd6:  r = ~b;
         5'd7: begin
            wide = longint'(a) * (longint'(1) << sh);
            r = wide[31:0];
         end
         5'd8: begin
            wide = longint'(a) / (longint'(1) << sh);
            r = wide[31:0];
         end
         5'd9: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
         end
         5'd10: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
         end
         5'd11: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
         end
         5'd14, 5'd15: begin
            wide = longint'(a) + longint'(b) + ((op == 5'd15) ? longint'(c_in) : 0);
            r = wide[31:0];
            c = (wide >= 64'sh1_0000_0000);
            sgn = longint'($signed(a)) + longint'($signed(b)) +
                  ((op == 5'd15) ? longint'(c_in) : 0);
            o = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
         end
         5'd16, 5'd17: begin
            // borrow: sub never borrows in, subb borrows when C is clear
            wide = longint'(a) - longint'(b) - ((op == 5'd17) ? longint'(!c_in) : 0);
            r = wide[31:0];
            c = (wide >= 0);
            sgn = longint'($signed(a)) - longint'($signed(b)) -
                  ((op == 5'd17) ? longint'(!c_in) : 0);
            o = (sgn > 64'sd2147483647) || (sgn < -64'sd2147483648);
         end
`ifdef ALU_MUL_EN
         5'd18: begin
            wide = longint'(a) * longint'(b);
            r = wide[31:0];
         end
`endif
         default: r = 32'd0;
      endcase
      nf = {o, r[31], (r == 32'd0), c};
      if (opc == 5'd0 || opc == 5'd1) res = r;
      else if (opc == 5'd2) res = b;
      else if (opc >= 5'd3 && opc <= 5'd11) res = a + b;
      else res = 32'd0;
   endtask

   task automatic drive(input logic [4:0] opc, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic bub);
      opcode    = opc;
      alu_op    = op;
      lhs       = a;
      rhs       = b;
      bubble_in = bub;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(5'd0, 5'd14, 32'hFFFF_FFFF, 32'd1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (flags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected %b", flags, 4'b0000);
      end else begin
         $display("reset_flags: flags=%b", flags);
      end
      @(negedge clk);
      rst = 1'b0;
      m_flags = 4'b0000;
   endtask

   // Spec vectors with constant expectations in sequence
   task automatic test_directed();
      logic [4:0]  t_opc [10];
      logic [4:0]  t_op  [10];
      logic [31:0] t_a   [10];
      logic [31:0] t_b   [10];
      logic        t_bub [10];
      logic [31:0] t_res [10];
      logic [3:0]  t_flg [10];
      t_opc = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd2, 5'd1};
      t_op  = '{5'd14, 5'd16, 5'd14, 5'd14, 5'd15, 5'd15, 5'd9, 5'd14, 5'd0, 5'd18};
      t_a   = '{32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                32'h8000_0000, 32'h100, 32'hDEAD_BEEF, 32'd6};
      t_b   = '{32'd1, 32'd7, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4, 32'd8,
                32'h1234_5678, 32'd7};
      t_bub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ALU_MUL_EN
      t_res = '{32'd0, 32'hFFFF_FFFE, 32'h8000_0000, 32'd1, 32'd6, 32'd6,
                32'hF800_0000, 32'h108, 32'h1234_5678, 32'd42};
      t_flg = '{4'b0011, 4'b0100, 4'b1100, 4'b0001, 4'b0001, 4'b0000,
                4'b0100, 4'b0100, 4'b0100, 4'b0000};
`else
      t_res = '{32'd0, 32'hFFFF_FFFE, 32'h8000_0000, 32'd1, 32'd6, 32'd6,
                32'hF800_0000, 32'h108, 32'h1234_5678, 32'd0};
      t_flg = '{4'b0011, 4'b0100, 4'b1100, 4'b0001, 4'b0001, 4'b0000,
                4'b0100, 4'b0100, 4'b0100, 4'b0010};
`endif
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(t_opc[i], t_op[i], t_a[i], t_b[i], t_bub[i]);
         #1;
         checks++;
         if (result !== t_res[i]) begin
            errors++;
            $display("FAIL directed_result[%0d]: got %h expected %h", i, result, t_res[i]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (flags !== t_flg[i]) begin
            errors++;
            $display("FAIL directed_flags[%0d]: got %b expected %b", i, flags, t_flg[i]);
         end else begin
            $display("directed[%0d]: opc=%0d op=%0d a=%h b=%h bub=%0d res=%h flags=%b",
                     i, t_opc[i], t_op[i], t_a[i], t_b[i], t_bub[i], result, flags);
         end
      end
      m_flags = t_flg[9];
   endtask

   task automatic test_random(input int n);
      logic [31:0] corner [5];
      logic [4:0]  opc;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        bub;
      logic [31:0] exp_res;
      logic [3:0]  nf;
      corner = '{32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1};
      for (int i = 0; i < n; i++) begin
         opc = ($urandom_range(0, 7) < 5) ? 5'($urandom_range(0, 1))
                                          : 5'($urandom_range(0, 31));
         op  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 17))
                                           : 5'($urandom_range(0, 31));
         a   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b   = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         bub = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         drive(opc, op, a, b, bub);
         ref_model(opc, op, a, b, m_flags[0], exp_res, nf);
         #1;
         checks++;
         if (result !== exp_res) begin
            errors++;
            $display("FAIL random_result[%0d]: opc=%0d op=%0d a=%h b=%h got %h expected %h",
                     i, opc, op, a, b, result, exp_res);
         end
         @(posedge clk);
         #1;
         if (!bub && (opc == 5'd0 || opc == 5'd1)) m_flags = nf;
         checks++;
         if (flags !== m_flags) begin
            errors++;
            $display("FAIL random_flags[%0d]: opc=%0d op=%0d a=%h b=%h bub=%0d got %b expected %b",
                     i, opc, op, a, b, bub, flags, m_flags);
         end else begin
            $display("random[%0d]: opc=%0d op=%0d a=%h b=%h bub=%0d res=%h flags=%b",
                     i, opc, op, a, b, bub, result, flags);
         end
      end
   endtask

   // Back-to-back carry chain: 64-bit add and subtract built from two ops
   task automatic test_back_to_back();
      logic [63:0] x;
      logic [63:0] y;
      logic [63:0] got;
      logic [63:0] want;
      for (int k = 0; k < 8; k++) begin
         x = {$urandom, $urandom};
         y = {$urandom, $urandom};
         for (int s = 0; s < 2; s++) begin
            want = (s == 0) ? x + y : x - y;
            @(negedge clk);
            drive(5'd0, (s == 0) ? 5'd14 : 5'd16, x[31:0], y[31:0], 1'b0);
            #1;
            got[31:0] = result;
            @(negedge clk);
            drive(5'd0, (s == 0) ? 5'd15 : 5'd17, x[63:32], y[63:32], 1'b0);
            #1;
            got[63:32] = result;
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL chain64[%0d.%0d]: got %h expected %h", k, s, got, want);
            end else begin
               $display("chain64[%0d.%0d]: x=%h y=%h res=%h", k, s, x, y, got);
            end
         end
      end
      @(posedge clk);
      #1;
      // resync model with a known flag-producing op
      @(negedge clk);
      drive(5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      m_flags = 4'b0010;
      checks++;
      if (flags !== m_flags) begin
         errors++;
         $display("FAIL chain_resync: got %b expected %b", flags, m_flags);
      end
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      drive(5'd0, 5'd14, 32'hFFFF_FFFF, 32'd1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (flags !== 4'b0011) begin
         errors++;
         $display("FAIL rstprio_setup: got %b expected %b", flags, 4'b0011);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(5'd0, 5'd14, 32'h7FFF_FFFF, 32'd1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (flags !== 4'b0000) begin
         errors++;
         $display("FAIL rstprio_flags: got %b expected %b", flags, 4'b0000);
      end else begin
         $display("rstprio: flags=%b", flags);
      end
      @(negedge clk);
      rst = 1'b0;
      m_flags = 4'b0000;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      m_flags = 4'b0000;
      rst = 1'b1;
      drive(5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
      test_reset();
      test_directed();
      test_random(300);
      test_back_to_back();
      test_reset_priority();
      test_random(100);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
